imem_loader: RTL

Program loader that sits directly upstream of the fetch stage's instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes them into consecutive instruction-memory locations starting at a programmable base address. It computes a running checksum and holds the core in reset until the load completes. It replaces hierarchical preloading of instruction memory with a synthesizable path.

---
 rtl/imem_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams instruction words into instruction memory from a base address,
// keeping a running checksum and holding the core in reset until the load completes.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum,
  output logic              core_rst
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [31:0]       checksum_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              core_rst_q;

  logic              hs;
  logic [ADDR_W:0]   end_addr;

  // Wrap-around check is done one bit wider than the address so base+count==DEPTH stays legal.
  assign end_addr = {1'b0, base_addr} + word_count;
  assign hs       = in_valid && (state_q == LOAD);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      core_rst_q  <= 1'b0;
    end else begin
      im_we_q    <= 1'b0;
      core_rst_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            checksum_q  <= '0;
            addr_q      <= base_addr;
            remaining_q <= word_count;
            if (end_addr > DEPTH) begin
              state_q <= ERR;
            end else if (word_count == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= LOAD;
            end
          end else if (state_q == DONE) begin
            // One cycle behind DONE so the final write retires before the core runs.
            core_rst_q <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            im_we_q     <= 1'b1;
            im_addr_q   <= addr_q;
            im_wdata_q  <= in_data;
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            checksum_q  <= checksum_q + in_data;
          end
          if (abort) begin
            state_q <= IDLE;
          end else if (hs && remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign checksum = checksum_q;
  assign core_rst = core_rst_q;

endmodule
